mips_pipeline_cpu: RTL and testbench
====================================

Name: mips_pipeline_cpu

Overview:
- 32-bit MIPS-subset processor core with a classic 5-stage pipeline: IF, ID, EX, MEM, WB.
- Harvard interface: separate program bus (instruction fetch) and data bus (load/store). Both memories are external and read combinationally.
- Top-level compute block of the MIPS CPU design. Memories and peripherals attach to its bus ports.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Prog_BUS_READ  input  32  instruction word at ADDR_Prog, valid combinationally in the same cycle.
- ADDR_Prog  output  32  byte address of fetch (equals PC).
- CS_P  output  1  program-memory chip select.
- Data_BUS_READ  input  32  load data at ADDR, valid combinationally during the MEM-stage cycle.
- ADDR  output  32  data byte address (EX/MEM ALU result).
- Data_BUS_WRITE  output  32  store data.
- CS  output  1  data-memory chip select; high only in the MEM cycle of LW/SW.
- WR_RD  output  1  1 = write (SW), 0 = read.

Behaviour:
- Reset (async, active-high):
  - PC = RESET_PC.
  - All pipeline registers hold NOP (32'h0) with control cleared.
  - All 32 registers = 0.
  - Outputs: CS_P=0, CS=0, WR_RD=0, ADDR=0, Data_BUS_WRITE=0.
  - Reset asserted mid-operation discards all in-flight instructions immediately.
- After reset, CS_P=1 every cycle. PC advances by 4 per cycle and wraps 0xFFFFFFFC -> 0.
- ISA (all other encodings execute as NOP: no register write, no memory access):
  - R-type, opcode 0: ADD f=0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A (signed), MUL f=0x18.
  - MUL: rd = rs[15:0]*rt[15:0], unsigned, 32-bit result, combinational in EX.
  - ADDI 0x08: sign-extended immediate.
  - LW 0x23 and SW 0x2B: address = rs + sext(imm).
  - BEQ 0x04: target = PC+4 + (sext(imm)<<2).
  - J 0x02: target = {PC+4[31:28], imm26, 2'b00}.
- Arithmetic: 32-bit wrap-around; no overflow exception.
- Register $0 reads 0; writes to $0 are ignored.
- Register file:
  - Written in WB on the rising edge.
  - A WB write is bypassed to an ID read of the same register in the same cycle (write-first).
- Latency: instruction fetched at cycle n reaches MEM at n+3 (data bus active) and writes back at n+4.
- Internal signal writeBack (32) carries the WB-stage result (ALU result or load data) for debug visibility.
- Load data path: Data_BUS_READ is captured into MEM/WB at the end of the MEM cycle.
- Control flow:
  - J resolves in ID: the IF instruction is squashed, 1 bubble.
  - BEQ resolves in EX: when taken, the IF and ID instructions are squashed (2 bubbles).
  - BEQ not taken: no penalty.
  - A J in ID and a taken BEQ in EX in the same cycle: the BEQ wins.
- No load-use interlock; software must insert 1 NOP after LW before a dependent instruction.
- No stalls: the pipeline advances every cycle.

Optional Feature:
- Macro FORWARDING_EN.
- Defined:
  - EX operands are forwarded from EX/MEM (ALU result) and from MEM/WB (writeBack).
  - EX/MEM has priority. No forwarding when the destination is $0.
  - Applies to SW store data too.
- Undefined:
  - Operands come only from the register file with its write-first bypass.
  - A dependent instruction must follow its producer by at least 3 slots, or it reads the stale value.

Test Plan:
- Reset and fetch:
  - Hold reset 100 ns: CS_P=0, CS=0, ADDR_Prog=0.
  - Release: ADDR_Prog = 0, 4, 8, 12 on successive cycles; CS_P=1.
- Unsupported encoding: constant Prog_BUS_READ=32'h0000064F (funct 0x0F) and Data_BUS_READ=32'h22B4 for 175 us.
  - CS never asserts and no register changes.
  - PC increments monotonically by 4.
- Store: ADDI $1,$0,5 (20010005), 3 NOPs, SW $1,8($0) (AC010008).
  - In the SW MEM cycle: CS=1, WR_RD=1, ADDR=8, Data_BUS_WRITE=5.
- Load: LW $2,0($0) (8C020000) with Data_BUS_READ=32'h22B4.
  - MEM cycle: CS=1, WR_RD=0, ADDR=0.
  - Next cycle: writeBack=32'h000022B4.
- Forwarding: ADDI $1,$0,3; ADD $2,$1,$1 back-to-back; 3 NOPs; SW $2,0($0).
  - With FORWARDING_EN: Data_BUS_WRITE=6.
  - Without FORWARDING_EN: Data_BUS_WRITE=0.
- Branch: BEQ $0,$0,+4 at address 0.
  - Fetch sequence 0, 4, 8, 20.
  - Instructions at 4 and 8 are squashed (no writeback, CS stays 0).

Source files
------------

// File: rtl/mips_pipeline_cpu.sv
// Five-stage MIPS-subset core (IF/ID/EX/MEM/WB) with Harvard program/data buses.
// Define FORWARDING_EN to forward EX/MEM and MEM/WB results into EX operands.
module mips_pipeline_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [31:0] Prog_BUS_READ,
    output logic [31:0] ADDR_Prog,
    output logic        CS_P,
    input  logic [31:0] Data_BUS_READ,
    output logic [31:0] ADDR,
    output logic [31:0] Data_BUS_WRITE,
    output logic        CS,
    output logic        WR_RD
);

    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
        OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J
    } op_t;

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;

    op_t         id_ex_op;
    logic [4:0]  id_ex_rs;
    logic [4:0]  id_ex_rt;
    logic [4:0]  id_ex_dest;
    logic        id_ex_reg_write;
    logic [31:0] id_ex_rs_val;
    logic [31:0] id_ex_rt_val;
    logic [31:0] id_ex_imm;
    logic [31:0] id_ex_pc4;

    logic [31:0] ex_mem_alu;
    logic [31:0] ex_mem_store_data;
    logic [4:0]  ex_mem_dest;
    logic        ex_mem_reg_write;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;

    logic [31:0] mem_wb_result;
    logic [4:0]  mem_wb_dest;
    logic        mem_wb_reg_write;
    logic [31:0] writeBack;

    logic [31:0] reg_file [0:31];

    // ID stage decode
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_imm;
    op_t         id_op;
    logic [4:0]  id_dest;
    logic        id_reg_write;
    logic [31:0] id_rs_val;
    logic [31:0] id_rt_val;
    logic        id_jump;
    logic [31:0] id_jump_target;
    logic [4:0]  unused_shamt;

    // EX stage
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_alu;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;

    assign pc_plus4  = pc + 32'd4;
    assign ADDR_Prog = pc;
    assign CS_P      = ~reset;

    assign id_opcode    = if_id_instr[31:26];
    assign id_rs        = if_id_instr[25:21];
    assign id_rt        = if_id_instr[20:16];
    assign id_rd        = if_id_instr[15:11];
    assign id_funct     = if_id_instr[5:0];
    assign id_imm       = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    assign unused_shamt = if_id_instr[10:6];

    always_comb begin
        id_op = OP_NOP;
        case (id_opcode)
            6'h00: begin
                case (id_funct)
                    6'h20:   id_op = OP_ADD;
                    6'h22:   id_op = OP_SUB;
                    6'h24:   id_op = OP_AND;
                    6'h25:   id_op = OP_OR;
                    6'h2A:   id_op = OP_SLT;
                    6'h18:   id_op = OP_MUL;
                    default: id_op = OP_NOP;
                endcase
            end
            6'h08:   id_op = OP_ADDI;
            6'h23:   id_op = OP_LW;
            6'h2B:   id_op = OP_SW;
            6'h04:   id_op = OP_BEQ;
            6'h02:   id_op = OP_J;
            default: id_op = OP_NOP;
        endcase
    end

    always_comb begin
        id_dest = 5'd0;
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: id_dest = id_rd;
            OP_ADDI, OP_LW:                                id_dest = id_rt;
            default:                                       id_dest = 5'd0;
        endcase
    end

    assign id_reg_write   = (id_dest != 5'd0);
    assign id_jump        = (id_op == OP_J);
    assign id_jump_target = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

    // Write-first: a same-cycle WB write to the register being read wins
    always_comb begin
        id_rs_val = reg_file[id_rs];
        id_rt_val = reg_file[id_rt];
        if (mem_wb_reg_write && (mem_wb_dest == id_rs))
            id_rs_val = writeBack;
        if (mem_wb_reg_write && (mem_wb_dest == id_rt))
            id_rt_val = writeBack;
        if (id_rs == 5'd0)
            id_rs_val = 32'h0;
        if (id_rt == 5'd0)
            id_rt_val = 32'h0;
    end

`ifdef FORWARDING_EN
    always_comb begin
        ex_a = id_ex_rs_val;
        ex_b = id_ex_rt_val;
        if (ex_mem_reg_write && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rs))
            ex_a = ex_mem_alu;
        else if (mem_wb_reg_write && (mem_wb_dest != 5'd0) && (mem_wb_dest == id_ex_rs))
            ex_a = writeBack;
        if (ex_mem_reg_write && (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rt))
            ex_b = ex_mem_alu;
        else if (mem_wb_reg_write && (mem_wb_dest != 5'd0) && (mem_wb_dest == id_ex_rt))
            ex_b = writeBack;
    end
`else
    logic [9:0] unused_fwd_regs;
    assign unused_fwd_regs = {id_ex_rs, id_ex_rt};
    assign ex_a = id_ex_rs_val;
    assign ex_b = id_ex_rt_val;
`endif

    always_comb begin
        ex_alu = 32'h0;
        case (id_ex_op)
            OP_ADD:                 ex_alu = ex_a + ex_b;
            OP_SUB:                 ex_alu = ex_a - ex_b;
            OP_AND:                 ex_alu = ex_a & ex_b;
            OP_OR:                  ex_alu = ex_a | ex_b;
            OP_SLT:                 ex_alu = {31'h0, $signed(ex_a) < $signed(ex_b)};
            OP_MUL:                 ex_alu = {16'h0, ex_a[15:0]} * {16'h0, ex_b[15:0]};
            OP_ADDI, OP_LW, OP_SW:  ex_alu = ex_a + id_ex_imm;
            default:                ex_alu = 32'h0;
        endcase
    end

    assign ex_branch_taken  = (id_ex_op == OP_BEQ) && (ex_a == ex_b);
    assign ex_branch_target = id_ex_pc4 + {id_ex_imm[29:0], 2'b00};

    // A taken BEQ in EX outranks a J in ID; both squash the fetch slot
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            if_id_instr <= 32'h0;
            if_id_pc4   <= 32'h0;
        end else begin
            if (ex_branch_taken)
                pc <= ex_branch_target;
            else if (id_jump)
                pc <= id_jump_target;
            else
                pc <= pc_plus4;
            if_id_instr <= (ex_branch_taken || id_jump) ? 32'h0 : Prog_BUS_READ;
            if_id_pc4   <= pc_plus4;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            id_ex_op        <= OP_NOP;
            id_ex_rs        <= 5'd0;
            id_ex_rt        <= 5'd0;
            id_ex_dest      <= 5'd0;
            id_ex_reg_write <= 1'b0;
            id_ex_rs_val    <= 32'h0;
            id_ex_rt_val    <= 32'h0;
            id_ex_imm       <= 32'h0;
            id_ex_pc4       <= 32'h0;
        end else if (ex_branch_taken) begin
            id_ex_op        <= OP_NOP;
            id_ex_rs        <= 5'd0;
            id_ex_rt        <= 5'd0;
            id_ex_dest      <= 5'd0;
            id_ex_reg_write <= 1'b0;
            id_ex_rs_val    <= 32'h0;
            id_ex_rt_val    <= 32'h0;
            id_ex_imm       <= 32'h0;
            id_ex_pc4       <= 32'h0;
        end else begin
            id_ex_op        <= id_op;
            id_ex_rs        <= id_rs;
            id_ex_rt        <= id_rt;
            id_ex_dest      <= id_dest;
            id_ex_reg_write <= id_reg_write;
            id_ex_rs_val    <= id_rs_val;
            id_ex_rt_val    <= id_rt_val;
            id_ex_imm       <= id_imm;
            id_ex_pc4       <= if_id_pc4;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            ex_mem_alu        <= 32'h0;
            ex_mem_store_data <= 32'h0;
            ex_mem_dest       <= 5'd0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            mem_wb_result     <= 32'h0;
            mem_wb_dest       <= 5'd0;
            mem_wb_reg_write  <= 1'b0;
        end else begin
            ex_mem_alu        <= ex_alu;
            ex_mem_store_data <= ex_b;
            ex_mem_dest       <= id_ex_dest;
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_read   <= (id_ex_op == OP_LW);
            ex_mem_mem_write  <= (id_ex_op == OP_SW);
            mem_wb_result     <= ex_mem_mem_read ? Data_BUS_READ : ex_mem_alu;
            mem_wb_dest       <= ex_mem_dest;
            mem_wb_reg_write  <= ex_mem_reg_write;
        end
    end

    assign writeBack = mem_wb_result;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                reg_file[i] <= 32'h0;
        end else if (mem_wb_reg_write && (mem_wb_dest != 5'd0)) begin
            reg_file[mem_wb_dest] <= writeBack;
        end
    end

    assign ADDR           = ex_mem_alu;
    assign Data_BUS_WRITE = ex_mem_store_data;
    assign CS             = ex_mem_mem_read | ex_mem_mem_write;
    assign WR_RD          = ex_mem_mem_write;

endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// Directed bench for mips_pipeline_cpu: fetch, no-op encodings, ALU, load/store,
// forwarding (follows FORWARDING_EN) and branch/jump squashing, with a bus scoreboard.
module tb_mips_pipeline_cpu;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Prog_BUS_READ;
    logic [31:0] ADDR_Prog;
    logic        CS_P;
    logic [31:0] Data_BUS_READ = 32'h0;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic        CS;
    logic        WR_RD;

    logic [31:0] imem [0:63];
    logic        const_mode = 1'b0;

    logic [31:0] exp_pc   [0:63];
    logic        exp_pc_v [0:63];
    logic [31:0] exp_wb   [0:63];
    logic        exp_wb_v [0:63];

    typedef struct {
        string       tag;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_t;
    bus_t bus_q[$];

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    assign Prog_BUS_READ = const_mode ? 32'h0000064F :
                           ((ADDR_Prog[31:8] == 24'h0) ? imem[ADDR_Prog[7:2]] : 32'h0);

    mips_pipeline_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .Prog_BUS_READ  (Prog_BUS_READ),
        .ADDR_Prog      (ADDR_Prog),
        .CS_P           (CS_P),
        .Data_BUS_READ  (Data_BUS_READ),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .CS             (CS),
        .WR_RD          (WR_RD)
    );

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int f);
        logic [31:0] w;
        w = 32'h0;
        w[25:21] = rs[4:0];
        w[20:16] = rt[4:0];
        w[15:11] = rd[4:0];
        w[5:0]   = f[5:0];
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        logic [31:0] w;
        w = 32'h0;
        w[31:26] = op[5:0];
        w[25:21] = rs[4:0];
        w[20:16] = rt[4:0];
        w[15:0]  = imm[15:0];
        return w;
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] target);
        return {6'h02, target[27:2]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clearProgram();
        for (int i = 0; i < 64; i++) begin
            imem[i]     = 32'h0;
            exp_pc_v[i] = 1'b0;
            exp_wb_v[i] = 1'b0;
        end
        bus_q.delete();
        Data_BUS_READ = 32'h0;
    endtask

    task automatic expectBus(input string tag, input logic wr, input logic [31:0] addr, input logic [31:0] data);
        bus_t e;
        e.tag = tag;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        bus_q.push_back(e);
    endtask

    // Sample i is taken during cycle i after reset release (cycle 0 fetches RESET_PC)
    task automatic applyStimulus(input int n);
        @(negedge CLK);
        reset = 1'b1;
        #100;
        @(negedge CLK);
        reset = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            if (i > 0)
                @(negedge CLK);
            checkOutput($sformatf("CS_P[%0d]", i), {31'h0, CS_P}, 32'h1);
            if (exp_pc_v[i])
                checkOutput($sformatf("ADDR_Prog[%0d]", i), ADDR_Prog, exp_pc[i]);
            if (exp_wb_v[i])
                checkOutput($sformatf("writeBack[%0d]", i), dut.writeBack, exp_wb[i]);
        end
        checkOutput("bus transactions outstanding", bus_q.size(), 32'h0);
    endtask

    // Scoreboard: every data-bus access must match the next queued expectation
    always @(negedge CLK) begin
        bus_t e;
        if (!reset && CS === 1'b1) begin
            if (bus_q.size() == 0) begin
                checkOutput($sformatf("unexpected CS addr=%h", ADDR), {31'h0, CS}, 32'h0);
            end else begin
                e = bus_q.pop_front();
                checkOutput({e.tag, " WR_RD"}, {31'h0, WR_RD}, {31'h0, e.wr});
                checkOutput({e.tag, " ADDR"}, ADDR, e.addr);
                checkOutput({e.tag, " Data_BUS_WRITE"}, Data_BUS_WRITE, e.data);
            end
        end
    end

    initial begin
        logic [31:0] pc_model;
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic [31:0] fwd_exp;

        $display("[TB] start");
        clearProgram();

        // Reset values while reset is held
        #100;
        checkOutput("reset CS_P", {31'h0, CS_P}, 32'h0);
        checkOutput("reset CS", {31'h0, CS}, 32'h0);
        checkOutput("reset ADDR_Prog", ADDR_Prog, 32'h0);
        checkOutput("reset WR_RD", {31'h0, WR_RD}, 32'h0);
        checkOutput("reset ADDR", ADDR, 32'h0);
        checkOutput("reset Data_BUS_WRITE", Data_BUS_WRITE, 32'h0);

        // Fetch sequence after release
        for (int i = 0; i < 4; i++) begin
            exp_pc[i] = 32'(4 * i);
            exp_pc_v[i] = 1'b1;
        end
        applyStimulus(6);

        // Unsupported encoding held on the program bus
        clearProgram();
        const_mode = 1'b1;
        Data_BUS_READ = 32'h22B4;
        @(negedge CLK);
        reset = 1'b1;
        #100;
        @(negedge CLK);
        reset = 1'b0;
        #1;
        pc_model = 32'h0;
        for (int i = 0; i < 17500; i++) begin
            if (i > 0)
                @(negedge CLK);
            checkOutput("unsupported PC step", ADDR_Prog, pc_model);
            pc_model = pc_model + 32'd4;
        end
        for (int r = 0; r < 32; r++)
            checkOutput($sformatf("unsupported reg[%0d]", r), dut.reg_file[r], 32'h0);
        const_mode = 1'b0;

        // Store
        clearProgram();
        imem[0] = enc_i(8'h08, 0, 1, 5);
        imem[4] = enc_i(8'h2B, 0, 1, 8);
        exp_wb[4] = 32'd5;
        exp_wb_v[4] = 1'b1;
        expectBus("store", 1'b1, 32'd8, 32'd5);
        applyStimulus(12);

        // Load
        clearProgram();
        Data_BUS_READ = 32'h22B4;
        imem[0] = enc_i(8'h23, 0, 2, 0);
        expectBus("load", 1'b0, 32'd0, 32'd0);
        exp_wb[4] = 32'h0000_22B4;
        exp_wb_v[4] = 1'b1;
        applyStimulus(8);
        checkOutput("load reg[2]", dut.reg_file[2], 32'h0000_22B4);

        // ALU operations, producers three slots ahead of consumers
        clearProgram();
        a_val = 32'hFFFF_FFFD;
        b_val = 32'd5;
        imem[0] = enc_i(8'h08, 0, 1, -3);
        imem[1] = enc_i(8'h08, 0, 2, 5);
        imem[4] = enc_r(1, 2, 3, 8'h22);
        imem[5] = enc_r(1, 2, 4, 8'h24);
        imem[6] = enc_r(1, 2, 5, 8'h25);
        imem[7] = enc_r(1, 2, 6, 8'h2A);
        imem[8] = enc_r(1, 2, 7, 8'h18);
        imem[9] = enc_r(1, 2, 8, 8'h20);
        exp_wb[4]  = a_val;
        exp_wb[5]  = b_val;
        exp_wb[8]  = a_val - b_val;
        exp_wb[9]  = a_val & b_val;
        exp_wb[10] = a_val | b_val;
        exp_wb[11] = 32'd1;
        exp_wb[12] = 32'd65533 * 32'd5;
        exp_wb[13] = a_val + b_val;
        foreach (exp_wb_v[i])
            exp_wb_v[i] = (i == 4 || i == 5 || (i >= 8 && i <= 13));
        applyStimulus(16);

        // Back-to-back dependency
        clearProgram();
`ifdef FORWARDING_EN
        fwd_exp = 32'd6;
`else
        fwd_exp = 32'd0;
`endif
        imem[0] = enc_i(8'h08, 0, 1, 3);
        imem[1] = enc_r(1, 1, 2, 8'h20);
        imem[5] = enc_i(8'h2B, 0, 2, 0);
        exp_wb[5] = fwd_exp;
        exp_wb_v[5] = 1'b1;
        expectBus("forward store", 1'b1, 32'd0, fwd_exp);
        applyStimulus(12);

        // Taken BEQ at 0 with a J behind it: BEQ wins, slots 4 and 8 squashed
        clearProgram();
        imem[0]  = enc_i(8'h04, 0, 0, 4);
        imem[1]  = enc_j(32'h40);
        imem[2]  = enc_i(8'h2B, 0, 0, 0);
        imem[5]  = enc_i(8'h08, 0, 4, 9);
        imem[16] = enc_i(8'h08, 0, 5, 1);
        exp_pc[0] = 32'd0;  exp_pc[1] = 32'd4;  exp_pc[2] = 32'd8;
        exp_pc[3] = 32'd20; exp_pc[4] = 32'd24;
        for (int i = 0; i < 5; i++)
            exp_pc_v[i] = 1'b1;
        exp_wb[5] = 32'd0;  exp_wb_v[5] = 1'b1;
        exp_wb[7] = 32'd9;  exp_wb_v[7] = 1'b1;
        applyStimulus(12);
        checkOutput("branch reg[4]", dut.reg_file[4], 32'd9);
        checkOutput("branch reg[5]", dut.reg_file[5], 32'd0);

        // J from 0 to 0x40: slot at 4 squashed
        clearProgram();
        imem[0]  = enc_j(32'h40);
        imem[1]  = enc_i(8'h08, 0, 3, 7);
        imem[16] = enc_i(8'h08, 0, 6, 2);
        exp_pc[0] = 32'd0;    exp_pc[1] = 32'd4;
        exp_pc[2] = 32'h40;   exp_pc[3] = 32'h44;
        for (int i = 0; i < 4; i++)
            exp_pc_v[i] = 1'b1;
        exp_wb[5] = 32'd0;  exp_wb_v[5] = 1'b1;
        exp_wb[6] = 32'd2;  exp_wb_v[6] = 1'b1;
        applyStimulus(10);
        checkOutput("jump reg[3]", dut.reg_file[3], 32'd0);
        checkOutput("jump reg[6]", dut.reg_file[6], 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
